// File: rtl/tia_playfield_scanner.sv
// Playfield scanner: owns the horizontal colour-clock counter and serialises the
// 20-bit playfield (PF0[7:4], PF1, PF2) across the 160 visible pixels.
module tia_playfield_scanner #(
    parameter int HBLANK_CLOCKS  = 68,
    parameter int LINE_CLOCKS    = 228,
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       resync,
    input  logic [3:0] pf0,
    input  logic [7:0] pf1,
    input  logic [7:0] pf2,
    input  logic       reflect,
    input  logic       score,
    output logic [7:0] hpos,
    output logic       pf_visible,
    output logic       pf_out,
    output logic       pf_half,
    output logic [4:0] bit_index,
    output logic       score_sel
);

    localparam logic [7:0] HALF_PIXELS = 8'd80;
    localparam logic [7:0] NUM_BITS    = 8'd20;

    logic [7:0]  hpos_q, hpos_d;
    logic        visible_q, pf_out_q, half_q, score_sel_q, refl_q;
    logic [4:0]  bit_index_q;

    logic [7:0]  v, bit_pos;
    logic        visible, half, boundary, refl_eff, pf_bit;
    logic [4:0]  k, idx;
    logic [19:0] logical;

    always_comb begin
        if (resync || (hpos_q == 8'(LINE_CLOCKS - 1))) begin
            hpos_d = 8'd0;
        end else begin
            hpos_d = hpos_q + 8'd1;
        end
    end

    // logical[k] is the playfield bit shown at left-half bit position k
    always_comb begin
        logical        = '0;
        logical[3:0]   = pf0;
        logical[19:12] = pf2;
        for (int i = 0; i < 8; i++) begin
            logical[4 + i] = pf1[7 - i];
        end
    end

    always_comb begin
        visible  = (hpos_q >= 8'(HBLANK_CLOCKS));
        v        = hpos_q - 8'(HBLANK_CLOCKS);
        half     = (v >= HALF_PIXELS);
        bit_pos  = v / 8'(CLOCKS_PER_BIT);
        k        = (bit_pos >= NUM_BITS) ? 5'(bit_pos - NUM_BITS) : 5'(bit_pos);
        boundary = ((v % 8'(CLOCKS_PER_BIT)) == 8'd0);
        // The first right-half pixel uses the reflect value being captured now
        refl_eff = (v == HALF_PIXELS) ? reflect : refl_q;
        idx      = (half && refl_eff) ? (5'd19 - k) : k;
        pf_bit   = logical[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q      <= 8'd0;
            visible_q   <= 1'b0;
            pf_out_q    <= 1'b0;
            half_q      <= 1'b0;
            bit_index_q <= 5'd0;
            score_sel_q <= 1'b0;
            refl_q      <= 1'b0;
        end else begin
            hpos_q <= hpos_d;
            if (visible) begin
                if (v == HALF_PIXELS) begin
                    refl_q <= reflect;
                end
                if (boundary) begin
                    pf_out_q    <= pf_bit;
                    bit_index_q <= idx;
                end
                visible_q   <= 1'b1;
                half_q      <= half;
                score_sel_q <= score & half;
            end else begin
                visible_q   <= 1'b0;
                pf_out_q    <= 1'b0;
                half_q      <= 1'b0;
                bit_index_q <= 5'd0;
                score_sel_q <= 1'b0;
            end
        end
    end

    assign hpos       = hpos_q;
    assign pf_visible = visible_q;
    assign pf_out     = pf_out_q;
    assign pf_half    = half_q;
    assign bit_index  = bit_index_q;
    assign score_sel  = score_sel_q;

endmodule
